// File: rtl/serializer_ctrl_if.sv
// rtl/serializer_ctrl_if.sv - upstream symbol-pair stream into serializer_ctrl
interface serializer_ctrl_if;
    logic         in_valid;
    logic         in_ready;
    logic [131:0] in_lane0;
    logic [131:0] in_lane1;

    modport master (
        output in_valid,
        output in_lane0,
        output in_lane1,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_lane0,
        input  in_lane1,
        output in_ready
    );
endinterface

// File: rtl/serializer_ctrl.sv
// rtl/serializer_ctrl.sv - 2-entry symbol-pair buffer feeding a two-lane serializer
// with selectable symbol period, stop at symbol boundaries and idle substitution.
module serializer_ctrl (
    input  logic                clk,
    input  logic                rst,
    serializer_ctrl_if.slave    up,
    input  logic                start,
    input  logic                stop,
    input  logic [1:0]          gen_speed,
    output logic                ser_enable,
    output logic [131:0]        ser_lane0,
    output logic [131:0]        ser_lane1,
    output logic                busy,
    output logic                underflow,
    output logic [15:0]         sym_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t       state;
    logic [7:0]   period;
    logic [7:0]   bit_cnt;
    logic         stop_pend;

    logic [263:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic         full;
    logic         empty;
    logic         push;
    logic         pop;
    logic         at_boundary;
    logic [263:0] head;

    function automatic logic [7:0] period_of(input logic [1:0] gs);
        case (gs)
            2'b01:   period_of = 8'd132;
            2'b10:   period_of = 8'd66;
            default: period_of = 8'd8;
        endcase
    endfunction

    assign full        = (count == 2'd2);
    assign empty       = (count == 2'd0);
    assign up.in_ready = !full;
    assign push        = up.in_valid && !full;
    assign head        = mem[rd_ptr];
    assign at_boundary = (bit_cnt == (period - 8'd1));
    assign busy        = (state != IDLE);

    // A pending or same-cycle stop always wins over popping the next symbol.
    always_comb begin
        pop = 1'b0;
        case (state)
            PRIME:   pop = !stop && !empty;
            RUN:     pop = at_boundary && !stop && !stop_pend && !empty;
            default: pop = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {up.in_lane1, up.in_lane0};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            period     <= 8'd8;
            bit_cnt    <= 8'd0;
            stop_pend  <= 1'b0;
            ser_enable <= 1'b0;
            ser_lane0  <= '0;
            ser_lane1  <= '0;
            underflow  <= 1'b0;
            sym_count  <= 16'd0;
        end else begin
            underflow <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= PRIME;
                        period    <= period_of(gen_speed);
                        sym_count <= 16'd0;
                        stop_pend <= 1'b0;
                        bit_cnt   <= 8'd0;
                    end
                end
                PRIME: begin
                    if (stop) begin
                        state <= IDLE;
                    end else if (pop) begin
                        ser_lane0  <= head[131:0];
                        ser_lane1  <= head[263:132];
                        ser_enable <= 1'b1;
                        bit_cnt    <= 8'd0;
                        sym_count  <= sym_count + 16'd1;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    if (at_boundary) begin
                        bit_cnt <= 8'd0;
                        if (stop || stop_pend) begin
                            state      <= IDLE;
                            stop_pend  <= 1'b0;
                            ser_enable <= 1'b0;
                            ser_lane0  <= '0;
                            ser_lane1  <= '0;
                        end else begin
                            sym_count <= sym_count + 16'd1;
                            if (pop) begin
                                ser_lane0 <= head[131:0];
                                ser_lane1 <= head[263:132];
                            end else begin
                                ser_lane0 <= '0;
                                ser_lane1 <= '0;
                                underflow <= 1'b1;
                            end
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 8'd1;
                        if (stop) stop_pend <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/serializer_ctrl.md
SERIALIZER_CTRL -- requirements
Module: serializer_ctrl

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low; ports are named clk and rst.
REQ-002 clk  input  1  rising-edge clock, one cycle per serial bit-time.
REQ-003 rst  input  1  asynchronous active-low reset.
REQ-004 start  input  1  single-cycle request to begin transmission; sampled only in IDLE.
REQ-005 stop  input  1  single-cycle request to end transmission at the next symbol boundary.
REQ-006 gen_speed  input  2  symbol period select: 00 -> 8, 01 -> 132, 10 -> 66, 11 -> 8 cycles.
REQ-007 in_valid  input  1  upstream symbol-pair valid.
REQ-008 in_ready  output  1  block can accept a symbol pair.
REQ-009 in_lane0, in_lane1  input  132 each  upstream symbols for lanes 0 and 1.
REQ-010 ser_enable  output  1  enable to the lane serializer.
REQ-011 ser_lane0, ser_lane1  output  132 each  parallel words presented to the serializer.
REQ-012 busy  output  1  high whenever the state is not IDLE.
REQ-013 underflow  output  1  one-cycle pulse when an idle (all-zero) symbol is substituted.
REQ-014 sym_count  output  16  count of symbol pairs delivered since the last start.

Function
REQ-015 Buffer SHALL be a 2-entry FIFO of 264-bit entries (lane1 & lane0); push when in_valid && in_ready.
REQ-016 in_ready SHALL equal "FIFO not full", combinationally.
REQ-017 States SHALL be IDLE, PRIME, RUN.
REQ-018 IDLE: ser_enable = 0; ser_lane0/1 = 0; start -> PRIME; gen_speed latched into period P on that edge.
REQ-019 PRIME: FIFO non-empty -> pop head into ser_lane0/1, set ser_enable = 1, set bit_cnt = 0, go to RUN.
REQ-020 PRIME: stop -> IDLE with no pop; stop has priority over a same-cycle pop.
REQ-021 RUN: bit_cnt SHALL increment each cycle and wrap to 0 after reaching P-1.
REQ-022 The first RUN cycle and every cycle with bit_cnt = 0 is a serializer load cycle; ser_lane0/1 SHALL be stable during it.
REQ-023 RUN boundary (bit_cnt = P-1, no stop pending): load the FIFO head if non-empty (pop); otherwise load all-zero and pulse underflow on the following cycle.
REQ-024 stop in RUN SHALL set stop_pend; at the next boundary the block SHALL go to IDLE with ser_enable = 0 and ser_lane0/1 = 0, with no pop.
REQ-025 stop arriving on the boundary cycle itself SHALL take effect at that boundary.
REQ-026 start outside IDLE SHALL be ignored; gen_speed changes outside IDLE SHALL be ignored until the next start.
REQ-027 sym_count SHALL clear on start and increment by 1 on each load into ser_lane0/1, including PRIME loads and idle substitutions; it wraps from 0xFFFF to 0.
REQ-028 Push and pop in the same cycle SHALL leave the occupancy unchanged; pop of the single entry with no push leaves the FIFO empty.
REQ-029 FIFO contents SHALL persist across stop/IDLE and SHALL be sent first on the next start.
REQ-030 Latency SHALL be: start -> ser_enable high 2 cycles later when the FIFO is non-empty.

Reset
REQ-031 On rst low: state = IDLE, FIFO empty, bit_cnt = 0, stop_pend = 0, P = 8.
REQ-032 On rst low: ser_enable = 0, ser_lane0/1 = 0, busy = 0, underflow = 0, sym_count = 0, in_ready = 1.
REQ-033 Reset asserted mid-RUN SHALL discard all buffered data immediately, with no boundary wait.

Verification
REQ-034 Push A, B; gen_speed = 00; start -> ser_enable rises; A is held for 8 cycles, then B for 8 cycles, then zeros with an underflow pulse; sym_count = 3.
REQ-035 gen_speed = 01; push 3 pairs -> in_ready falls after 2 pushes; each word is held for 132 cycles; the third push is accepted after the first pop.
REQ-036 gen_speed = 10; stop at bit_cnt = 10 -> ser_enable falls exactly at the 66-cycle boundary; the remaining FIFO entry is sent first after the next start.
REQ-037 start with an empty FIFO -> stays in PRIME with busy = 1; push C -> C is loaded 1 cycle later; stop issued in PRIME instead -> IDLE with no load.
REQ-038 rst pulsed low mid-symbol with the FIFO full -> all outputs go to reset values immediately and in_ready = 1.
REQ-039 Change gen_speed from 00 to 01 during RUN -> the period stays 8 until stop and restart, then becomes 132.
